// File: rtl/il_branch_pkg.sv
// Shared encodings for the branch controller: control-flow opcodes,
// controller FSM states and small opcode classification helpers.
package il_branch_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_JMP   = 3'd1,
        OP_JMPC  = 3'd2,
        OP_JMPCN = 3'd3,
        OP_CAL   = 3'd4,
        OP_CALC  = 3'd5,
        OP_CALCN = 3'd6,
        OP_RET   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BR   = 2'd1,
        ST_FL   = 2'd2
    } state_e;

    // True when the op would redirect the PC given the accumulator bit.
    function automatic logic op_taken(input op_e op, input logic cond);
        logic taken;
        case (op)
            OP_JMP, OP_CAL, OP_RET: taken = 1'b1;
            OP_JMPC, OP_CALC:       taken = cond;
            OP_JMPCN, OP_CALCN:     taken = ~cond;
            default:                taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic op_is_call(input op_e op);
        return (op == OP_CAL) || (op == OP_CALC) || (op == OP_CALCN);
    endfunction

endpackage

// File: rtl/branch_ctrl_ret_stack.sv
// ret_stack: LIFO of return addresses.
//   clk, reset : clock, synchronous active-high reset (clears occupancy only)
//   push       : write push_data on top (ignored when full)
//   pop        : discard top entry (ignored when empty; push has priority)
//   push_data  : address to push
//   data       : current top entry (valid when not empty)
//   depth      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
module ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               data,
    output logic [$clog2(DEPTH)+1-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic [AW-1:0] wr_idx, rd_idx;

    always_comb begin
        wr_idx = depth_q[AW-1:0];
        // Wraps to DEPTH-1 when the stack is full (wr_idx == 0).
        rd_idx = wr_idx - AW'(1);
        full   = (depth_q == FULL_CNT);
        empty  = (depth_q == '0);
        data   = mem_q[rd_idx];
        depth  = depth_q;
    end

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            depth_d       = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry contents need no reset: only occupancy defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: execute-stage control-flow resolution with a return stack.
//   clk, reset  : clock, synchronous active-high reset
//   opValid     : control-flow op present this cycle
//   opCode      : NONE/JMP/JMPC/JMPCN/CAL/CALC/CALCN/RET
//   cond        : accumulator condition bit for conditional ops
//   target      : jump/call destination
//   pcCur       : address of the instruction in execute
//   branch      : one-cycle PC load strobe
//   branchAddr  : PC load value, held while branch=0
//   flush       : squash fetch/decode (branch cycle plus one)
//   stackErr    : sticky return-stack overflow/underflow flag
//   depth       : return-stack occupancy
module branch_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             opValid,
    input  logic [2:0]                       opCode,
    input  logic                             cond,
    input  logic [ADDR_W-1:0]                target,
    input  logic [ADDR_W-1:0]                pcCur,
    output logic                             branch,
    output logic [ADDR_W-1:0]                branchAddr,
    output logic                             flush,
    output logic                             stackErr,
    output logic [$clog2(STACK_DEPTH)+1-1:0] depth
);

    import il_branch_pkg::*;

    state_e            state_q, state_d;
    logic              branch_q, branch_d;
    logic              flush_q, flush_d;
    logic              stack_err_q, stack_err_d;
    logic [ADDR_W-1:0] branch_addr_q, branch_addr_d;

    op_e               op;
    logic              push, pop;
    logic [ADDR_W-1:0] ret_addr, stack_top;
    logic              stack_full, stack_empty;

    assign op       = op_e'(opCode);
    assign ret_addr = pcCur + ADDR_W'(1);

    ret_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .data      (stack_top),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        state_d       = state_q;
        stack_err_d   = stack_err_q;
        branch_addr_d = branch_addr_q;
        push          = 1'b0;
        pop           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (opValid && op_taken(op, cond)) begin
                    if (op_is_call(op)) begin
                        if (stack_full) begin
                            stack_err_d = 1'b1;
                        end else begin
                            push          = 1'b1;
                            branch_addr_d = target;
                            state_d       = ST_BR;
                        end
                    end else if (op == OP_RET) begin
                        if (stack_empty) begin
                            stack_err_d = 1'b1;
                        end else begin
                            pop           = 1'b1;
                            branch_addr_d = stack_top;
                            state_d       = ST_BR;
                        end
                    end else begin
                        branch_addr_d = target;
                        state_d       = ST_BR;
                    end
                end
            end
            ST_BR:   state_d = ST_FL;
            ST_FL:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered copies decoded from the next state so that
        // they line up with the state register without extra latency.
        branch_d = (state_d == ST_BR);
        flush_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            branch_q      <= 1'b0;
            flush_q       <= 1'b0;
            stack_err_q   <= 1'b0;
            branch_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            branch_q      <= branch_d;
            flush_q       <= flush_d;
            stack_err_q   <= stack_err_d;
            branch_addr_q <= branch_addr_d;
        end
    end

    assign branch     = branch_q;
    assign flush      = flush_q;
    assign stackErr   = stack_err_q;
    assign branchAddr = branch_addr_q;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 8;
    localparam int DW          = $clog2(STACK_DEPTH) + 1;

    localparam logic [2:0] NONE = 3'd0, JMP = 3'd1, JMPC = 3'd2, JMPCN = 3'd3;
    localparam logic [2:0] CAL = 3'd4, CALC = 3'd5, CALCN = 3'd6, RET = 3'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic              opValid;
    logic [2:0]        opCode;
    logic              cond;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pcCur;
    logic              branch;
    logic [ADDR_W-1:0] branchAddr;
    logic              flush;
    logic              stackErr;
    logic [DW-1:0]     depth;

    branch_ctrl #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opValid    (opValid),
        .opCode     (opCode),
        .cond       (cond),
        .target     (target),
        .pcCur      (pcCur),
        .branch     (branch),
        .branchAddr (branchAddr),
        .flush      (flush),
        .stackErr   (stackErr),
        .depth      (depth)
    );

    always #5 clk = ~clk;

    // Reference model: cycles left in the redirect window, a queue stack.
    int                busy_left;
    logic [ADDR_W-1:0] m_addr;
    bit                m_err;
    logic [ADDR_W-1:0] m_stack[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit redirects(input logic [2:0] op, input logic c);
        if (op == JMP || op == CAL || op == RET) return 1'b1;
        if (op == JMPC || op == CALC) return c;
        if (op == JMPCN || op == CALCN) return !c;
        return 1'b0;
    endfunction

    task automatic model_edge();
        if (reset) begin
            busy_left = 0;
            m_addr    = '0;
            m_err     = 1'b0;
            m_stack.delete();
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (opValid && redirects(opCode, cond)) begin
            if (opCode >= CAL && opCode <= CALCN) begin
                if (m_stack.size() == STACK_DEPTH) m_err = 1'b1;
                else begin
                    m_stack.push_back(ADDR_W'((int'(pcCur) + 1) % (1 << ADDR_W)));
                    m_addr    = target;
                    busy_left = 2;
                end
            end else if (opCode == RET) begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else begin
                    m_addr    = m_stack.pop_back();
                    busy_left = 2;
                end
            end else begin
                m_addr    = target;
                busy_left = 2;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("branch", branch, busy_left == 2);
        check("flush", flush, busy_left != 0);
        check("branchAddr", branchAddr, m_addr);
        check("stackErr", stackErr, m_err);
        check("depth", depth, m_stack.size());
    endtask

    task automatic idle_inputs();
        reset   = 1'b0;
        opValid = 1'b0;
        opCode  = NONE;
        cond    = 1'b0;
        target  = '0;
        pcCur   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [2:0] code, input logic c,
                         input logic [ADDR_W-1:0] t, input logic [ADDR_W-1:0] pc);
        opValid = 1'b1;
        opCode  = code;
        cond    = c;
        target  = t;
        pcCur   = pc;
        step();
        idle_inputs();
    endtask

    initial begin
        busy_left = 0;
        m_addr    = '0;
        m_err     = 1'b0;
        idle_inputs();

        // Reset state
        do_reset();
        check("rst_branch", branch, 0);
        check("rst_flush", flush, 0);
        check("rst_depth", depth, 0);

        // Unconditional jump
        issue(JMP, 1'b0, 8'h3C, 8'h00);
        check("jmp_branch", branch, 1);
        check("jmp_addr", branchAddr, 8'h3C);
        step();
        check("jmp_fl_flush", flush, 1);
        check("jmp_fl_branch", branch, 0);
        step();
        check("jmp_idle_flush", flush, 0);

        // Call / return
        issue(CAL, 1'b0, 8'h40, 8'h12);
        check("cal_addr", branchAddr, 8'h40);
        check("cal_depth", depth, 1);
        step();
        step();
        issue(RET, 1'b0, 8'h00, 8'h00);
        check("ret_addr", branchAddr, 8'h13);
        check("ret_depth", depth, 0);
        step();
        step();

        // Conditionals
        issue(JMPC, 1'b0, 8'h77, 8'h00);
        check("jmpc_nt", branch, 0);
        issue(JMPCN, 1'b0, 8'h05, 8'h00);
        check("jmpcn_addr", branchAddr, 8'h05);
        step();
        step();
        issue(CALCN, 1'b1, 8'h50, 8'h10);
        check("calcn_nt_depth", depth, 0);

        // Overflow
        do_reset();
        for (int i = 0; i < STACK_DEPTH; i++) begin
            issue(CAL, 1'b0, 8'h80, ADDR_W'(i));
            step();
            step();
        end
        check("full_depth", depth, STACK_DEPTH);
        issue(CAL, 1'b0, 8'h90, 8'h20);
        check("ovf_branch", branch, 0);
        check("ovf_err", stackErr, 1);
        step();
        check("ovf_sticky", stackErr, 1);

        // Underflow
        do_reset();
        issue(RET, 1'b0, 8'h00, 8'h00);
        check("unf_branch", branch, 0);
        check("unf_err", stackErr, 1);

        // Return-address wrap and ops squashed in BR/FL
        do_reset();
        issue(CAL, 1'b0, 8'h20, 8'hFF);
        step();
        step();
        issue(RET, 1'b0, 8'h00, 8'h00);
        check("wrap_addr", branchAddr, 8'h00);
        step();
        step();
        issue(JMP, 1'b0, 8'h11, 8'h00);
        issue(JMP, 1'b0, 8'h22, 8'h00);
        check("sq_br_branch", branch, 0);
        issue(JMP, 1'b0, 8'h33, 8'h00);
        check("sq_fl_branch", branch, 0);
        check("sq_fl_flush", flush, 0);
        check("sq_addr", branchAddr, 8'h11);

        // Reset during FL with three entries stacked
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(CAL, 1'b0, 8'hA0, ADDR_W'(i));
            if (i < 2) begin
                step();
                step();
            end
        end
        step();
        check("pre_rst_fl", flush, 1);
        check("pre_rst_depth", depth, 3);
        reset   = 1'b1;
        opValid = 1'b1;
        opCode  = JMP;
        target  = 8'h44;
        step();
        check("mid_rst_flush", flush, 0);
        check("mid_rst_depth", depth, 0);
        check("mid_rst_err", stackErr, 0);
        idle_inputs();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 149) == 0);
            opValid = ($urandom_range(0, 3) != 0);
            opCode  = 3'($urandom_range(0, 7));
            cond    = 1'($urandom_range(0, 1));
            target  = ADDR_W'($urandom);
            pcCur   = ADDR_W'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, instruction address width; SHALL equal `instAddrLen.
REQ-002 Parameter STACK_DEPTH, default 8, number of return-address entries; SHALL be a power of 2, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 opValid  input  1  an execute-stage control-flow op is present this cycle.
REQ-006 opCode  input  3  0 NONE, 1 JMP, 2 JMPC, 3 JMPCN, 4 CAL, 5 CALC, 6 CALCN, 7 RET.
REQ-007 cond  input  1  accumulator condition bit for the conditional ops.
REQ-008 target  input  ADDR_W  jump or call destination.
REQ-009 pcCur  input  ADDR_W  address of the instruction in execute.
REQ-010 branch  output  1  drives the program counter branch input.
REQ-011 branchAddr  output  ADDR_W  drives the program counter pcIn.
REQ-012 flush  output  1  squashes fetch/decode stages.
REQ-013 stackErr  output  1  sticky error flag for return-stack overflow or underflow.
REQ-014 depth  output  $clog2(STACK_DEPTH)+1  current return-stack occupancy.

Function
REQ-015 An op is taken when opValid=1, the FSM is in IDLE, and one of: JMP/CAL/RET; JMPC/CALC with cond=1; JMPCN/CALCN with cond=0.
REQ-016 FSM states: IDLE, BR, FL; IDLE->BR on a taken op; BR->FL unconditionally; FL->IDLE unconditionally.
REQ-017 In BR: branch=1, flush=1, branchAddr=resolved destination; each asserted for exactly one cycle.
REQ-018 In FL: branch=0, flush=1; in IDLE: branch=0, flush=0.
REQ-019 Latency: a taken op sampled at edge N SHALL produce branch=1 during cycle N+1.
REQ-020 Ops presented in BR or FL SHALL be ignored: no stack change, no error, no branch.
REQ-021 JMP-class destination = target.
REQ-022 CAL-class: push (pcCur+1) mod 2^ADDR_W; destination = target.
REQ-023 RET: pop top entry; destination = popped value.
REQ-024 Push and pop SHALL update depth at the same edge that enters BR.
REQ-025 CAL-class with depth=STACK_DEPTH: no push, no branch, FSM stays IDLE, stackErr set.
REQ-026 RET with depth=0: no pop, no branch, FSM stays IDLE, stackErr set.
REQ-027 Non-taken conditional ops and NONE SHALL leave all state unchanged.
REQ-028 branchAddr SHALL hold its last value when branch=0.
REQ-029 stackErr SHALL remain set until reset.

Reset
REQ-030 reset=1 at an edge: FSM->IDLE, depth=0, stackErr=0, branch=0, flush=0, branchAddr=0.
REQ-031 Reset SHALL take priority over any op in the same cycle, including during BR or FL; stack contents are don't-care after reset.

Structure
REQ-032 Package il_branch_pkg SHALL hold the opCode encodings and the FSM state encoding.
REQ-033 Sub-module ret_stack (LIFO: push, pop, data, depth, full, empty; synchronous reset) SHALL hold the return addresses.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Unconditional jump: reset; JMP target=0x3C -> branch=1, branchAddr=0x3C for one cycle, flush=1 for two cycles, then idle.
REQ-036 Call/return: CAL target=0x40, pcCur=0x12 -> branch to 0x40, depth=1; after the FL cycle, RET -> branch to 0x13, depth=0.
REQ-037 Conditionals: JMPC cond=0 -> no branch. JMPCN cond=0 target=0x05 -> branch to 0x05. CALCN cond=1 -> depth unchanged.
REQ-038 Stack limits: 8 CALs (each spaced 3 cycles) -> depth=8; 9th CAL -> no branch, stackErr=1. After reset, RET -> no branch, stackErr=1.
REQ-039 Wrap and squash: CAL pcCur=0xFF -> pushed return address 0x00. A JMP issued during BR and another during FL -> both ignored.
REQ-040 Reset mid-operation: assert reset during FL with depth=3 -> next cycle flush=0, depth=0, stackErr=0.
